registered_fifo: RTL and testbench

- Ready/valid FIFO with fully registered ports, the complement of the zero-delay bypass FIFO.
- No combinational path between the two ports:
  - output_port_valid and output_port_data come from flops;
  - input_port_ready comes from a flop.
- Minimum latency is 1 cycle.
- Placed between a producer and a consumer to cut timing paths in both the forward direction and the backward (ready) direction.

---
 rtl/registered_fifo.sv | 106 ++++++++++
 tb/tb_registered_fifo.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/registered_fifo.sv
// Ready/valid FIFO whose ports are driven only from flops: an output register stage
// backed by a (DEPTH-1)-entry ring buffer, with a registered input-side ready.
module registered_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 10
) (
  input  logic                         clock_port,
  input  logic                         reset_port,
  input  logic                         clear,
  input  logic [DATA_WIDTH-1:0]        input_port_data,
  input  logic                         input_port_valid,
  output logic                         input_port_ready,
  output logic [DATA_WIDTH-1:0]        output_port_data,
  output logic                         output_port_valid,
  input  logic                         output_port_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW   = $clog2(DEPTH + 1);
  localparam int RING = DEPTH - 1;
  localparam int AW   = (RING > 1) ? $clog2(RING) : 1;
  localparam logic [AW-1:0] LAST = AW'(RING - 1);

  logic [DATA_WIDTH-1:0] mem_q [RING];

  logic                  ovalid_q, ovalid_d;
  logic [DATA_WIDTH-1:0] odata_q, odata_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ready_q, ready_d;
  logic [AW-1:0]         push_addr_q, push_addr_d;
  logic [AW-1:0]         pop_addr_q, pop_addr_d;
  logic                  looped_q, looped_d;

  logic push, pop, load, ring_empty, ring_we, push_wrap, pop_wrap;

  always_comb begin
    push        = input_port_valid & ready_q;
    pop         = ovalid_q & output_port_ready;
    load        = ~ovalid_q | pop;
    ring_empty  = (push_addr_q == pop_addr_q) & ~looped_q;
    ovalid_d    = ovalid_q;
    odata_d     = odata_q;
    push_addr_d = push_addr_q;
    pop_addr_d  = pop_addr_q;
    push_wrap   = 1'b0;
    pop_wrap    = 1'b0;
    ring_we     = 1'b0;

    // Ring contents always drain ahead of the incoming word to keep FIFO order.
    if (load) begin
      if (!ring_empty) begin
        odata_d    = mem_q[pop_addr_q];
        ovalid_d   = 1'b1;
        pop_wrap   = (pop_addr_q == LAST);
        pop_addr_d = pop_wrap ? '0 : pop_addr_q + AW'(1);
      end else if (push) begin
        odata_d  = input_port_data;
        ovalid_d = 1'b1;
      end else begin
        ovalid_d = 1'b0;
      end
    end

    ring_we = push & ~(load & ring_empty);
    if (ring_we) begin
      push_wrap   = (push_addr_q == LAST);
      push_addr_d = push_wrap ? '0 : push_addr_q + AW'(1);
    end

    looped_d = looped_q ^ push_wrap ^ pop_wrap;
    count_d  = count_q + CW'(push) - CW'(pop);
    ready_d  = (count_d != CW'(DEPTH));
  end

  always_ff @(posedge clock_port) begin
    if (reset_port || clear) begin
      ovalid_q    <= 1'b0;
      odata_q     <= '0;
      count_q     <= '0;
      ready_q     <= 1'b1;
      push_addr_q <= '0;
      pop_addr_q  <= '0;
      looped_q    <= 1'b0;
    end else begin
      ovalid_q    <= ovalid_d;
      odata_q     <= odata_d;
      count_q     <= count_d;
      ready_q     <= ready_d;
      push_addr_q <= push_addr_d;
      pop_addr_q  <= pop_addr_d;
      looped_q    <= looped_d;
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clock_port) begin
    if (ring_we && !reset_port && !clear)
      mem_q[push_addr_q] <= input_port_data;
  end

  assign output_port_valid = ovalid_q;
  assign output_port_data  = odata_q;
  assign input_port_ready  = ready_q;
  assign count             = count_q;

endmodule

// File: tb/tb_registered_fifo.sv
// Self-checking bench for registered_fifo: a queue-based FIFO model scores every
// cycle, while directed sequences exercise fill, drain, streaming, wrap and flush.
module tb_registered_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 10;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clock_port = 1'b0;
  logic          reset_port = 1'b1;
  logic          clear = 1'b0;
  logic [DW-1:0] input_port_data = '0;
  logic          input_port_valid = 1'b0;
  logic          input_port_ready;
  logic [DW-1:0] output_port_data;
  logic          output_port_valid;
  logic          output_port_ready = 1'b0;
  logic [CW-1:0] count;

  int tests = 0;
  int fails = 0;
  int xfers = 0;
  logic [DW-1:0] exp_q[$];

  registered_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clock_port        (clock_port),
    .reset_port        (reset_port),
    .clear             (clear),
    .input_port_data   (input_port_data),
    .input_port_valid  (input_port_valid),
    .input_port_ready  (input_port_ready),
    .output_port_data  (output_port_data),
    .output_port_valid (output_port_valid),
    .output_port_ready (output_port_ready),
    .count             (count)
  );

  always #5 clock_port = ~clock_port;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, let the edge consume them, return 1ns after it.
  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic r,
                               input logic clr, input logic rst);
    input_port_valid  = v;
    input_port_data   = d;
    output_port_ready = r;
    clear             = clr;
    reset_port        = rst;
    @(posedge clock_port);
    #1;
  endtask

  // Reference model: a plain queue of accepted words with capacity DEPTH.
  always @(posedge clock_port) begin
    int  sz;
    bit  p, o;
    sz = exp_q.size();
    if (reset_port || clear) begin
      exp_q.delete();
    end else begin
      p = input_port_valid && (sz != DEPTH);
      o = (sz > 0) && output_port_ready;
      if (o) begin
        void'(exp_q.pop_front());
        xfers++;
      end
      if (p) exp_q.push_back(input_port_data);
    end
  end

  always @(negedge clock_port) begin
    checkOutput("mon_count", 32'(count), exp_q.size());
    checkOutput("mon_valid", 32'(output_port_valid), 32'(exp_q.size() != 0));
    checkOutput("mon_ready", 32'(input_port_ready), 32'(exp_q.size() != DEPTH));
    if (output_port_valid && exp_q.size() > 0)
      checkOutput("mon_data", 32'(output_port_data), 32'(exp_q[0]));
  end

  task automatic flushTest(input bit use_reset);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
    checkOutput("flush_fill_count", 32'(count), 6);
    applyStimulus(1'b1, 8'hFF, 1'b1, !use_reset, use_reset);
    checkOutput(use_reset ? "reset_flush_valid" : "clear_flush_valid", 32'(output_port_valid), 0);
    checkOutput(use_reset ? "reset_flush_count" : "clear_flush_count", 32'(count), 0);
    checkOutput(use_reset ? "reset_flush_ready" : "clear_flush_ready", 32'(input_port_ready), 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
      checkOutput("flush_idle_valid", 32'(output_port_valid), 0);
    end
  endtask

  initial begin
    int start, cyc;
    @(posedge clock_port);
    #1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_valid", 32'(output_port_valid), 0);
    checkOutput("reset_data", 32'(output_port_data), 0);
    checkOutput("reset_count", 32'(count), 0);
    checkOutput("reset_ready", 32'(input_port_ready), 1);

    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    checkOutput("single_valid", 32'(output_port_valid), 1);
    checkOutput("single_data", 32'(output_port_data), 32'h A5);
    checkOutput("single_count", 32'(count), 1);
    applyStimulus(1'b0, 8'(($urandom)), 1'b1, 1'b0, 1'b0);
    checkOutput("single_pop_valid", 32'(output_port_valid), 0);
    checkOutput("single_pop_count", 32'(count), 0);

    for (int i = 1; i <= DEPTH; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    checkOutput("full_count", 32'(count), DEPTH);
    checkOutput("full_ready", 32'(input_port_ready), 0);
    applyStimulus(1'b1, 8'h0B, 1'b0, 1'b0, 1'b0);
    checkOutput("full_reject_count", 32'(count), DEPTH);
    for (int i = 1; i <= DEPTH; i++) begin
      checkOutput("drain_data", 32'(output_port_data), i);
      applyStimulus(1'b0, 8'(($urandom)), 1'b1, 1'b0, 1'b0);
      if (i == 1) checkOutput("drain_ready", 32'(input_port_ready), 1);
      checkOutput("drain_count", 32'(count), DEPTH - i);
    end
    checkOutput("drain_empty_valid", 32'(output_port_valid), 0);

    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
      checkOutput("stream_data", 32'(output_port_data), i);
      checkOutput("stream_count", 32'(count), 1);
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("stream_end_count", 32'(count), 0);

    start = xfers;
    cyc = 0;
    while ((xfers - start) < 1000 && cyc < 20000) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'(($urandom)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      cyc++;
    end
    checkOutput("random_xfer_budget", 32'((xfers - start) >= 1000), 1);
    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("random_drained_count", 32'(count), 0);

    flushTest(1'b0);
    flushTest(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
